// File: rtl/ir_diag_reader.sv
// Diagnostic EBUS initiator for the IR read-back port: wins the bus, steps DIAG READ 13x
// through subfunctions 0-7 and assembles a 48-bit status snapshot (KL numbering, bit 0 = MSB).
module ir_diag_reader #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned GRANT_TIMEOUT = 255
) (
  input  logic        eboxClk,
  input  logic        eboxReset_n,
  input  logic        start,
  input  logic        sweep,
  input  logic [2:0]  subSel,
  input  logic        ebusGrant,
  input  logic [5:0]  ebusData,
  output logic        ebusReq,
  output logic        diagReadFunc13x,
  output logic [2:0]  diagFunc,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        errTimeout,
  output logic        errLost,
  output logic [47:0] snapshot
);
  // state     | meaning
  // S_IDLE    | waiting for start
  // S_REQ     | requesting the EBUS, grant timeout running
  // S_DRIVE   | 13x asserted, settling then sampling the current subfunction
  // S_RELEASE | drivers off, request still held (bus turnaround)
  // S_DONE    | request dropped, done pulse
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DRIVE, S_RELEASE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [9:0] TMO_LAST    = 10'(GRANT_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic        r_sweep;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_settle, w_settle_nxt;
  logic [9:0]  r_tmo, w_tmo_nxt;
  logic        w_accept, w_sample, w_tmo_hit, w_lost;
  logic [5:0]  w_field_lo;

  logic        r_ebus_req, r_diag_rd, r_busy, r_done, r_valid, r_err_tmo, r_err_lost;
  logic [2:0]  r_diag_func;
  logic [47:0] r_snapshot;

  // field n lives at KL bits 6n..6n+5, i.e. vector bits [47-6n -: 6]
  assign w_field_lo = 6'd42 - 6'(r_idx) * 6'd6;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_settle_nxt = r_settle;
    w_tmo_nxt    = r_tmo;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_tmo_hit    = 1'b0;
    w_lost       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
          w_idx_nxt   = sweep ? 3'd0 : subSel;
          w_tmo_nxt   = '0;
        end
      end
      S_REQ: begin
        if (ebusGrant) begin
          w_state_nxt  = S_DRIVE;
          w_settle_nxt = SETTLE_LOAD;
        end else if (r_tmo == TMO_LAST) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_tmo_nxt = r_tmo + 10'd1;
        end
      end
      S_DRIVE: begin
        // a sample due on the same edge the grant is seen low is discarded
        if (!ebusGrant) begin
          w_lost      = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_settle == 4'd0) begin
          w_sample = 1'b1;
          if (r_sweep && (r_idx != 3'd7)) begin
            w_idx_nxt    = r_idx + 3'd1;
            w_settle_nxt = SETTLE_LOAD;
          end else begin
            w_state_nxt = S_RELEASE;
          end
        end else begin
          w_settle_nxt = r_settle - 4'd1;
        end
      end
      S_RELEASE: w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      r_state  <= S_IDLE;
      r_sweep  <= 1'b0;
      r_idx    <= '0;
      r_settle <= '0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_settle <= w_settle_nxt;
      r_tmo    <= w_tmo_nxt;
      if (w_accept) r_sweep <= sweep;
    end
  end

  // outputs are registered from the next state so they change on state entry
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      r_ebus_req  <= 1'b0;
      r_diag_rd   <= 1'b0;
      r_diag_func <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_lost  <= 1'b0;
      r_snapshot  <= '0;
    end else begin
      r_ebus_req <= (w_state_nxt == S_REQ) || (w_state_nxt == S_DRIVE) ||
                    (w_state_nxt == S_RELEASE);
      r_diag_rd  <= (w_state_nxt == S_DRIVE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DRIVE) r_diag_func <= w_idx_nxt;
      if (w_accept) begin
        r_valid    <= 1'b0;
        r_err_tmo  <= 1'b0;
        r_err_lost <= 1'b0;
      end
      if (r_state == S_RELEASE) r_valid <= 1'b1;
      if (w_tmo_hit) r_err_tmo <= 1'b1;
      if (w_lost) r_err_lost <= 1'b1;
      if (w_sample) r_snapshot[w_field_lo +: 6] <= ebusData;
    end
  end

  assign ebusReq         = r_ebus_req;
  assign diagReadFunc13x = r_diag_rd;
  assign diagFunc        = r_diag_func;
  assign busy            = r_busy;
  assign done            = r_done;
  assign valid           = r_valid;
  assign errTimeout      = r_err_tmo;
  assign errLost         = r_err_lost;
  assign snapshot        = r_snapshot;

endmodule

// File: doc/ir_diag_reader.md
Name: ir_diag_reader

Overview:
- Diagnostic EBUS initiator for the IR board's read-back port.
- Arbitrates for the EBUS, then asserts the DIAG READ 13x function with subfunction codes 0-7.
- Waits for the IR drivers to settle, then samples EBUS data bits 0:5 and assembles a 48-bit IR status snapshot for the console/diagnostic path.
- Sits beside CTL on the diagnostic side of the EBUS, opposite the IR board's EBUS driver.

Parameters:
- SETTLE_CYCLES, 3, cycles each subfunction code is held before sampling; legal range 1..15.
- GRANT_TIMEOUT, 255, cycles to wait for ebusGrant before aborting; legal range 1..1023.

Ports:
- eboxClk  in  1  EBOX clock; all state changes on its rising edge.
- eboxReset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- sweep  in  1  sampled with start: 1 = read all 8 subfunctions, 0 = read only subSel.
- subSel  in  3  subfunction to read when sweep=0.
- ebusGrant  in  1  EBUS arbiter grant.
- ebusData  in  6  EBUS data bits 0:5.
- ebusReq  out  1  EBUS request to arbiter.
- diagReadFunc13x  out  1  enables the IR EBUS drivers.
- diagFunc  out  3  DIAG_FUNC[4:6] subfunction code.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion, including aborts.
- valid  out  1  snapshot contents are good.
- errTimeout  out  1  sticky: grant never arrived.
- errLost  out  1  sticky: grant dropped while driving.
- snapshot  out  48  subfunction n data at bits [6n : 6n+5]; bit 0 is the MSB, KL numbering.

Behaviour:
- Reset: all outputs 0 asynchronously; state IDLE; internal counters 0.
- Register outputs: every output is registered; none is combinational from inputs.
- IDLE:
  - start=1 latches sweep, and subSel as the first index (0 when sweep=1).
  - Clears valid, errTimeout and errLost.
  - Next state REQ.
  - start outside IDLE is ignored.
- REQ:
  - ebusReq=1; the timeout counter increments each cycle.
  - ebusGrant=1 -> DRIVE.
  - Counter reaches GRANT_TIMEOUT without grant -> errTimeout=1, ebusReq=0, next state DONE.
- DRIVE:
  - diagReadFunc13x=1 and diagFunc=index, both updated on entry.
  - Settle counter runs SETTLE_CYCLES cycles; on the edge ending the last cycle, ebusData is written to snapshot[6*index +: 6].
  - Single read: after the sample, go to RELEASE.
  - Sweep, index<7: increment index, which updates diagFunc; diagReadFunc13x stays high; restart the settle counter.
  - Sweep, index=7: after the sample, go to RELEASE.
  - Snapshot fields not read in single mode keep their previous values.
- RELEASE (1 cycle): diagReadFunc13x=0, ebusReq still 1. This is the bus turnaround; the driver is off before the request drops.
- DONE (1 cycle):
  - ebusReq=0, done=1.
  - valid=1 unless an error flag is set.
  - Next state IDLE.
  - valid holds until the next accepted start.
- Grant lost: ebusGrant=0 during DRIVE -> next cycle diagReadFunc13x=0, ebusReq=0, errLost=1, state DONE with valid=0. A sample due in the same cycle as the grant loss is discarded.
- Latency with grant present on the REQ cycle (start accepted at T0):
  - Sweep: done at T0+2+8*SETTLE_CYCLES+1, i.e. T27 for SETTLE_CYCLES=3.
  - Single read: done at T0+3+SETTLE_CYCLES.
- Reset asserted mid-operation: bus released at once with all outputs 0; no done pulse.

Test Plan:
- Reset held, then released with idle inputs -> all outputs 0, busy=0, snapshot=0.
- start, sweep=1, grant tied 1, ebusData=6'o10+diagFunc -> done at T27; snapshot = 6'o10, 6'o11 … 6'o17 (48'o1011121314151617); valid=1; diagReadFunc13x high for cycles T2..T25.
- start, sweep=0, subSel=5, ebusData=6'o52, snapshot preloaded from the previous test -> done at T6; bits 30:35 = 6'o52, all other fields unchanged.
- Grant never asserted, GRANT_TIMEOUT=255 -> errTimeout=1, done pulse, valid=0, diagReadFunc13x never asserted.
- Sweep with grant dropped at the 10th DRIVE cycle -> one cycle later diagReadFunc13x=0, ebusReq=0, errLost=1, valid=0; a second start pulse while busy has no effect.
- eboxReset_n pulsed low mid-sweep -> ebusReq and diagReadFunc13x go 0 immediately, no done pulse; a subsequent sweep completes normally.
